dmem_port_arb: RTL and testbench
================================

# dmem_port_arb

Two-requester arbiter for the single data-memory port of the 5-stage pipelined core. The core's MEM stage (EX/MEM register outputs) has fixed priority. A secondary requester (debug loader / DMA) gets idle cycles. A starvation counter can force a one-cycle core hold so the secondary requester is always served. The block sits between the EX/MEM register and `datamemory`, replacing the direct MEM-stage wiring.

## Interface
Parameters:
- `ADDR_W`, 9: data-memory byte address width.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 8: consecutive denied cycles before a forced hold. Legal range 1..255.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `core_rd` in 1: MEM-stage read enable (EX/MEM MemRead).
- `core_wr` in 1: MEM-stage write enable (EX/MEM MemWrite).
- `core_addr` in ADDR_W: MEM-stage address (ALU result low bits).
- `core_wdata` in DATA_W: MEM-stage store data.
- `core_funct3` in 3: load/store size code.
- `core_rdata` out DATA_W: load data to the MEM/WB register.
- `core_hold` out 1: core must freeze all pipeline registers and PC this cycle, and re-present its MEM access next cycle.
- `ext_req` in 1: secondary request. Held high until granted.
- `ext_we` in 1: 1 = write, 0 = read.
- `ext_addr` in ADDR_W: secondary address.
- `ext_wdata` in DATA_W: secondary write data.
- `ext_gnt` out 1: one-cycle pulse. The access is performed in this cycle.
- `ext_rvalid` out 1: read data valid, one cycle after a granted read.
- `ext_rdata` out DATA_W: registered read data.
- `mem_rd`, `mem_wr` out 1: to `datamemory`.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_funct3` out 3: to `datamemory`.
- `mem_rdata` in DATA_W: combinational read data from `datamemory`.

## Operation
- **Core access:** `core_act = core_rd | core_wr`.
- **States:**
  - IDLE: normal arbitration.
  - HOLD: forced secondary slot.
- **IDLE behaviour:**
  - If `core_act`, the memory port is driven from the core inputs and `ext_gnt=0`.
  - Else, if `ext_req`, the memory port is driven from the ext inputs, `ext_gnt=1`, and `mem_funct3=3'b010` (word).
  - Else, `mem_rd=mem_wr=0`.
- **HOLD behaviour:**
  - `core_hold=1` and `ext_gnt=1`.
  - The memory port is driven from the ext inputs. The core access is blocked: `mem_rd`/`mem_wr` do not reflect core inputs.
  - Next state is IDLE.
- **Starvation counter `wait_cnt`:**
  - Increments each IDLE cycle with `ext_req & core_act`.
  - Clears on any `ext_gnt` and on any cycle with `ext_req=0`.
  - When `wait_cnt == STARVE_MAX-1` and the current cycle is denied, next state is HOLD.
  - `wait_cnt` clears entering HOLD, so HOLD is never back-to-back.
- **Core read data:** `core_rdata = mem_rdata` combinationally. It is undefined (don't-care) in ext-granted cycles.
- **Ext read data:** `ext_rdata` is registered from `mem_rdata` on a granted read. `ext_rvalid` pulses for one cycle. `ext_rdata` holds its value until the next granted read.
- **Granted ext write:** performed in the grant cycle. `ext_rvalid` stays 0.
- **`ext_req` dropped before grant:** no access, counter cleared, no state change.
- **Reset:** state IDLE, `wait_cnt=0`, `core_hold=0`, `ext_gnt=0`, `ext_rvalid=0`, `ext_rdata=0`, all `mem_*` enables 0. Reset asserted during HOLD returns to IDLE on the next edge; no access is performed in the reset cycle.

## Timing
- Grant decision is combinational from inputs and state. There is no added latency on the core path.
- `core_hold` and HOLD are registered state outputs, valid from the start of the cycle.
- Secondary worst-case latency: `STARVE_MAX` denied cycles, then grant in cycle `STARVE_MAX` (counting from the first denied cycle as 0).
- `ext_rvalid` comes 1 cycle after the grant.
- The core must sample `core_hold` in the same cycle and suppress every pipeline register update, including EX/MEM→MEM/WB.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - Starvation counter and HOLD state are present, as above.
- `DMEM_ARB_STARVE_EN` undefined:
  - No counter and no HOLD state; `core_hold` is tied 0.
  - The secondary requester is served only in cycles with `core_act=0`, and may starve indefinitely.

## Test plan
- **Idle grant:** `core_act=0`, ext read of addr 0x010 holding 0xDEADBEEF → `ext_gnt=1` the same cycle, then `ext_rvalid=1` with `ext_rdata=0xDEADBEEF` the next cycle.
- **Core priority:** `core_wr=1` to addr 0x020 with data 0x11111111, simultaneous ext write to 0x024 → core write is performed and `ext_gnt=0`. Next cycle `core_act=0` → ext write performed; a readback of 0x024 returns the ext data.
- **Starvation (STARVE_MAX=4, macro defined):** `core_rd` high continuously, `ext_req` from cycle 0 → denied in cycles 0–3; cycle 4 has `core_hold=1` and `ext_gnt=1`; cycle 5 is IDLE with the core access restored and `wait_cnt=0`.
- **Request withdrawal:** `ext_req` high for 3 denied cycles, then low for 1 cycle, then high → the count restarts; no HOLD occurs until 4 new denied cycles.
- **Reset in HOLD:** `reset` asserted in the HOLD cycle → next cycle IDLE, `core_hold=0`, `ext_rvalid=0`, no memory write performed.
- **Macro undefined:** same stimulus as the starvation test run for 50 cycles → `core_hold` is never 1 and `ext_gnt` is never 1.

Source files
------------

// File: rtl/dmem_port_arb.sv
// rtl/dmem_port_arb.sv - data-memory port arbiter: core MEM stage has priority, secondary requester takes idle slots
// Optional starvation guard (counter + forced one-cycle core hold) enabled by defining DMEM_ARB_STARVE_EN.
module dmem_port_arb #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_funct3,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_hold,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("dmem_port_arb: STARVE_MAX must be in 1..255");
    end

    logic              core_act;
    logic              hold_st;
    logic              ext_gnt_c;
    logic              ext_rvalid_q;
    logic              ext_rvalid_d;
    logic [DATA_W-1:0] ext_rdata_q;
    logic [DATA_W-1:0] ext_rdata_d;

    assign core_act = core_rd | core_wr;

`ifdef DMEM_ARB_STARVE_EN
    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(STARVE_MAX - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    // HOLD lasts one cycle and re-arms the counter from zero, so two HOLDs are never adjacent.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_HOLD) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
        end else if (ext_req && core_act) begin
            if (wait_cnt_q == WAIT_LAST) begin
                state_d    = ST_HOLD;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hold_st = (state_q == ST_HOLD);
`else
    assign hold_st = 1'b0;
`endif

    // Port steering; the reset cycle performs no access from either side.
    always_comb begin
        ext_gnt_c  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_funct3 = core_funct3;
        if (!reset) begin
            if (hold_st || (!core_act && ext_req)) begin
                ext_gnt_c  = 1'b1;
                mem_rd     = ~ext_we;
                mem_wr     = ext_we;
                mem_addr   = ext_addr;
                mem_wdata  = ext_wdata;
                mem_funct3 = 3'b010;
            end else begin
                mem_rd = core_rd;
                mem_wr = core_wr;
            end
        end
    end

    always_comb begin
        ext_rvalid_d = ext_gnt_c & ~ext_we;
        ext_rdata_d  = ext_rdata_q;
        if (ext_rvalid_d) begin
            ext_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign core_rdata = mem_rdata;
    assign core_hold  = hold_st;
    assign ext_gnt    = ext_gnt_c;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_port_arb.sv
// tb/tb_dmem_port_arb.sv - scoreboard bench for dmem_port_arb with a word-wide data-memory model
// Expectations for forced holds follow DMEM_ARB_STARVE_EN.
module tb_dmem_port_arb;

    localparam int STARVE = 4;

    logic        clk;
    logic        reset;
    logic        core_rd;
    logic        core_wr;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_hold;
    logic        ext_req;
    logic        ext_we;
    logic [8:0]  ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    logic [31:0] sb [$];
    int          n_vec  = 0;
    int          n_miss = 0;

    dmem_port_arb #(
        .ADDR_W    (9),
        .DATA_W    (32),
        .STARVE_MAX(STARVE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_funct3(core_funct3),
        .core_rdata (core_rdata),
        .core_hold  (core_hold),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_wr === 1'b1) mem[mem_addr[8:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (ext_rvalid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h, required no rvalid", ext_rdata);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (ext_rdata !== exp) begin
                    n_miss++;
                    $display("FAIL ext_rdata: got %h required %h", ext_rdata, exp);
                end
            end
        end
    end

    task automatic set_core(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d);
        core_rd     = rd;
        core_wr     = wr;
        core_addr   = a;
        core_wdata  = d;
        core_funct3 = 3'b010;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [8:0] a, input logic [31:0] d);
        ext_req   = req;
        ext_we    = we;
        ext_addr  = a;
        ext_wdata = d;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_core(1'b0, 1'b0, 9'h000, 32'h0);
        core_funct3 = 3'b001;
        set_ext(1'b0, 1'b0, 9'h000, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        set_core(1'b0, 1'b1, 9'h040, 32'hFFFF_FFFF);
        set_ext(1'b1, 1'b1, 9'h044, 32'hEEEE_EEEE);
        #1;
        n_vec++; if (mem_wr !== 1'b0) begin n_miss++; $display("FAIL reset_mem_wr: got %b required 0", mem_wr); end
        n_vec++; if (mem_rd !== 1'b0) begin n_miss++; $display("FAIL reset_mem_rd: got %b required 0", mem_rd); end
        n_vec++; if (ext_gnt !== 1'b0) begin n_miss++; $display("FAIL reset_ext_gnt: got %b required 0", ext_gnt); end
        @(negedge clk);
        #1;
        n_vec++; if (core_hold !== 1'b0) begin n_miss++; $display("FAIL reset_core_hold: got %b required 0", core_hold); end
        n_vec++; if (ext_rvalid !== 1'b0) begin n_miss++; $display("FAIL reset_ext_rvalid: got %b required 0", ext_rvalid); end
        n_vec++; if (ext_rdata !== 32'h0) begin n_miss++; $display("FAIL reset_ext_rdata: got %h required 0", ext_rdata); end
        idle_cycle();
        reset = 1'b0;
    endtask

    task automatic test_idle_grant();
        @(negedge clk);
        set_ext(1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF);
        #1;
        n_vec++; if (ext_gnt !== 1'b1) begin n_miss++; $display("FAIL idle_wr_gnt: got %b required 1", ext_gnt); end
        n_vec++; if (mem_wr !== 1'b1) begin n_miss++; $display("FAIL idle_wr_mem_wr: got %b required 1", mem_wr); end
        n_vec++; if (mem_funct3 !== 3'b010) begin n_miss++; $display("FAIL idle_wr_funct3: got %b required 010", mem_funct3); end
        @(negedge clk);
        set_ext(1'b1, 1'b0, 9'h010, 32'h0);
        #1;
        n_vec++; if (ext_gnt !== 1'b1) begin n_miss++; $display("FAIL idle_rd_gnt: got %b required 1", ext_gnt); end
        n_vec++; if (mem_rd !== 1'b1) begin n_miss++; $display("FAIL idle_rd_mem_rd: got %b required 1", mem_rd); end
        n_vec++; if (mem_addr !== 9'h010) begin n_miss++; $display("FAIL idle_rd_addr: got %h required 010", mem_addr); end
        n_vec++; if (core_hold !== 1'b0) begin n_miss++; $display("FAIL idle_rd_hold: got %b required 0", core_hold); end
        sb.push_back(32'hDEAD_BEEF);
        idle_cycle();
        #1;
        n_vec++; if (ext_rvalid !== 1'b1) begin n_miss++; $display("FAIL idle_rvalid: got %b required 1", ext_rvalid); end
        idle_cycle();
        #1;
        n_vec++; if (ext_rvalid !== 1'b0) begin n_miss++; $display("FAIL idle_rvalid_pulse: got %b required 0", ext_rvalid); end
        n_vec++; if (ext_rdata !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL idle_rdata_hold: got %h required deadbeef", ext_rdata); end
    endtask

    task automatic test_core_priority();
        @(negedge clk);
        set_core(1'b0, 1'b1, 9'h020, 32'h1111_1111);
        set_ext(1'b1, 1'b1, 9'h024, 32'hCAFE_F00D);
        #1;
        n_vec++; if (ext_gnt !== 1'b0) begin n_miss++; $display("FAIL prio_gnt: got %b required 0", ext_gnt); end
        n_vec++; if (mem_wr !== 1'b1) begin n_miss++; $display("FAIL prio_mem_wr: got %b required 1", mem_wr); end
        n_vec++; if (mem_addr !== 9'h020) begin n_miss++; $display("FAIL prio_addr: got %h required 020", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h1111_1111) begin n_miss++; $display("FAIL prio_wdata: got %h required 11111111", mem_wdata); end
        @(negedge clk);
        set_core(1'b0, 1'b0, 9'h020, 32'h0);
        #1;
        n_vec++; if (ext_gnt !== 1'b1) begin n_miss++; $display("FAIL prio_ext_gnt: got %b required 1", ext_gnt); end
        n_vec++; if (mem_addr !== 9'h024) begin n_miss++; $display("FAIL prio_ext_addr: got %h required 024", mem_addr); end
        n_vec++; if (mem_wdata !== 32'hCAFE_F00D) begin n_miss++; $display("FAIL prio_ext_wdata: got %h required cafef00d", mem_wdata); end
        @(negedge clk);
        set_ext(1'b0, 1'b0, 9'h000, 32'h0);
        set_core(1'b1, 1'b0, 9'h024, 32'h0);
        #1;
        n_vec++; if (core_rdata !== 32'hCAFE_F00D) begin n_miss++; $display("FAIL prio_readback_024: got %h required cafef00d", core_rdata); end
        n_vec++; if (ext_rvalid !== 1'b0) begin n_miss++; $display("FAIL prio_wr_no_rvalid: got %b required 0", ext_rvalid); end
        @(negedge clk);
        set_core(1'b1, 1'b0, 9'h020, 32'h0);
        #1;
        n_vec++; if (core_rdata !== 32'h1111_1111) begin n_miss++; $display("FAIL prio_readback_020: got %h required 11111111", core_rdata); end
        idle_cycle();
    endtask

    task automatic test_starvation();
        int ncyc;
`ifdef DMEM_ARB_STARVE_EN
        ncyc = 2 * (STARVE + 1);
`else
        ncyc = 50;
`endif
        for (int c = 0; c < ncyc; c++) begin
            logic       exp_hold;
            logic [8:0] exp_addr;
            @(negedge clk);
            set_core(1'b1, 1'b0, 9'h010, 32'h0);
            set_ext(1'b1, 1'b0, 9'h020, 32'h0);
            #1;
`ifdef DMEM_ARB_STARVE_EN
            exp_hold = ((c % (STARVE + 1)) == STARVE);
`else
            exp_hold = 1'b0;
`endif
            exp_addr = exp_hold ? 9'h020 : 9'h010;
            n_vec++; if (core_hold !== exp_hold) begin n_miss++; $display("FAIL starve_hold c%0d: got %b required %b", c, core_hold, exp_hold); end
            n_vec++; if (ext_gnt !== exp_hold) begin n_miss++; $display("FAIL starve_gnt c%0d: got %b required %b", c, ext_gnt, exp_hold); end
            n_vec++; if (mem_addr !== exp_addr) begin n_miss++; $display("FAIL starve_addr c%0d: got %h required %h", c, mem_addr, exp_addr); end
            n_vec++; if (mem_rd !== 1'b1) begin n_miss++; $display("FAIL starve_mem_rd c%0d: got %b required 1", c, mem_rd); end
            if (exp_hold) sb.push_back(32'h1111_1111);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_withdrawal();
        logic [8:0] req_pat;
        req_pat = 9'b1_1111_0111;
        for (int c = 0; c < 9; c++) begin
            logic exp_hold;
            @(negedge clk);
            set_core(1'b1, 1'b0, 9'h020, 32'h0);
            set_ext(req_pat[c], 1'b0, 9'h010, 32'h0);
            #1;
`ifdef DMEM_ARB_STARVE_EN
            exp_hold = (c == 8);
`else
            exp_hold = 1'b0;
`endif
            n_vec++; if (core_hold !== exp_hold) begin n_miss++; $display("FAIL wdraw_hold c%0d: got %b required %b", c, core_hold, exp_hold); end
            n_vec++; if (ext_gnt !== exp_hold) begin n_miss++; $display("FAIL wdraw_gnt c%0d: got %b required %b", c, ext_gnt, exp_hold); end
            if (exp_hold) sb.push_back(32'hDEAD_BEEF);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset_in_hold();
`ifdef DMEM_ARB_STARVE_EN
        @(negedge clk);
        set_core(1'b0, 1'b1, 9'h030, 32'hA5A5_A5A5);
        for (int c = 0; c < STARVE; c++) begin
            @(negedge clk);
            set_core(1'b1, 1'b0, 9'h010, 32'h0);
            set_ext(1'b1, 1'b1, 9'h030, 32'h5A5A_5A5A);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (core_hold !== 1'b1) begin n_miss++; $display("FAIL rsthold_in_hold: got %b required 1", core_hold); end
        n_vec++; if (mem_wr !== 1'b0) begin n_miss++; $display("FAIL rsthold_mem_wr: got %b required 0", mem_wr); end
        n_vec++; if (ext_gnt !== 1'b0) begin n_miss++; $display("FAIL rsthold_gnt: got %b required 0", ext_gnt); end
        @(negedge clk);
        reset = 1'b0;
        set_ext(1'b0, 1'b0, 9'h000, 32'h0);
        set_core(1'b1, 1'b0, 9'h030, 32'h0);
        #1;
        n_vec++; if (core_hold !== 1'b0) begin n_miss++; $display("FAIL rsthold_after_hold: got %b required 0", core_hold); end
        n_vec++; if (ext_rvalid !== 1'b0) begin n_miss++; $display("FAIL rsthold_rvalid: got %b required 0", ext_rvalid); end
        n_vec++; if (mem_rd !== 1'b1) begin n_miss++; $display("FAIL rsthold_core_rd: got %b required 1", mem_rd); end
        n_vec++; if (core_rdata !== 32'hA5A5_A5A5) begin n_miss++; $display("FAIL rsthold_no_write: got %h required a5a5a5a5", core_rdata); end
        idle_cycle();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_core(1'b0, 1'b0, 9'h000, 32'h0);
        set_ext(1'b0, 1'b0, 9'h000, 32'h0);
        test_reset();
        test_idle_grant();
        test_core_priority();
        test_starvation();
        test_withdrawal();
        test_reset_in_hold();
        idle_cycle();
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: got %0d pending reads, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
